// File: rtl/dmem_arb.sv
// dmem_arb: shares the single-port data memory between the cpu load/store path
// and an external loader/debug master; cpu has priority, ext starvation is bounded.
module dmem_arb #(
  parameter int DW     = 16,
  parameter int AW     = 8,
  parameter int STARVE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wd,
  output logic [DW-1:0] cpu_rd,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wd,
  output logic          ext_gnt,
  output logic          ext_ack,
  output logic [DW-1:0] ext_rd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd
);

  localparam int            CW       = (STARVE > 0) ? $clog2(STARVE + 1) : 1;
  localparam logic [CW-1:0] STARVE_C = CW'(STARVE);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] wait_cnt_r;
  logic [CW-1:0] wait_cnt_nxt_s;
  logic          ext_win_s;
  logic          ext_ack_r;
  logic [DW-1:0] ext_rd_r;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] val, input logic [CW-1:0] lim);
    if (val >= lim) begin
      sat_inc = lim;
    end else begin
      sat_inc = val + CW'(1);
    end
  endfunction

  // Arbitration decision and next state / starvation counter.
  always_comb begin
    ext_win_s      = 1'b0;
    state_nxt_s    = IDLE;
    wait_cnt_nxt_s = {CW{1'b0}};
    case (state_r)
      IDLE: begin
        ext_win_s = ext_req & (~cpu_req | (wait_cnt_r == STARVE_C));
        if (ext_win_s) begin
          state_nxt_s    = HOLD;
          wait_cnt_nxt_s = {CW{1'b0}};
        end else if (ext_req) begin
          state_nxt_s    = IDLE;
          wait_cnt_nxt_s = sat_inc(wait_cnt_r, STARVE_C);
        end else begin
          state_nxt_s    = IDLE;
          wait_cnt_nxt_s = {CW{1'b0}};
        end
      end
      // The ext request is still high from the op just served; it must not be re-served.
      HOLD: begin
        ext_win_s      = 1'b0;
        state_nxt_s    = IDLE;
        wait_cnt_nxt_s = {CW{1'b0}};
      end
      default: begin
        ext_win_s      = 1'b0;
        state_nxt_s    = IDLE;
        wait_cnt_nxt_s = {CW{1'b0}};
      end
    endcase
  end

  // Memory port steering; strobes are forced inactive while reset is held.
  always_comb begin
    mem_addr = cpu_addr;
    mem_wd   = cpu_wd;
    mem_we   = 1'b0;
    if (ext_win_s) begin
      mem_addr = ext_addr;
      mem_wd   = ext_wd;
      mem_we   = rst & ext_we;
    end else begin
      mem_addr = cpu_addr;
      mem_wd   = cpu_wd;
      mem_we   = rst & cpu_we & cpu_req;
    end
    ext_gnt   = rst & ext_win_s;
    cpu_stall = rst & ext_win_s & cpu_req;
  end

  assign cpu_rd  = mem_rd;
  assign ext_ack = ext_ack_r;
  assign ext_rd  = ext_rd_r;

  // State, starvation counter and registered ext response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      wait_cnt_r <= {CW{1'b0}};
      ext_ack_r  <= 1'b0;
      ext_rd_r   <= {DW{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      ext_ack_r  <= ext_win_s;
      if (ext_win_s) begin
        ext_rd_r <= mem_rd;
      end else begin
        ext_rd_r <= ext_rd_r;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arb.sv
// Self-checking bench for dmem_arb: STARVE=4 (dut_a) and STARVE=0 (dut_b) share
// stimulus; each has its own behavioural dmem; ext read data goes through a scoreboard.
module tb_dmem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [7:0]  cpu_addr, ext_addr;
  logic [15:0] cpu_wd, ext_wd;

  logic [15:0] cpu_rd_a, ext_rd_a, mem_wd_a, mem_rd_a;
  logic [7:0]  mem_addr_a;
  logic        cpu_stall_a, ext_gnt_a, ext_ack_a, mem_we_a;
  logic [15:0] cpu_rd_b, ext_rd_b, mem_wd_b, mem_rd_b;
  logic [7:0]  mem_addr_b;
  logic        cpu_stall_b, ext_gnt_b, ext_ack_b, mem_we_b;

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  logic [15:0] exp_q [$];
  logic [15:0] sb_exp;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  dmem_arb #(.DW(16), .AW(8), .STARVE(4)) dut_a (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd_a), .cpu_stall(cpu_stall_a),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wd(ext_wd),
    .ext_gnt(ext_gnt_a), .ext_ack(ext_ack_a), .ext_rd(ext_rd_a),
    .mem_addr(mem_addr_a), .mem_wd(mem_wd_a), .mem_we(mem_we_a), .mem_rd(mem_rd_a)
  );

  dmem_arb #(.DW(16), .AW(8), .STARVE(0)) dut_b (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd_b), .cpu_stall(cpu_stall_b),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wd(ext_wd),
    .ext_gnt(ext_gnt_b), .ext_ack(ext_ack_b), .ext_rd(ext_rd_b),
    .mem_addr(mem_addr_b), .mem_wd(mem_wd_b), .mem_we(mem_we_b), .mem_rd(mem_rd_b)
  );

  assign mem_rd_a = mem_a[mem_addr_a];
  assign mem_rd_b = mem_b[mem_addr_b];

  always @(posedge clk) begin
    if (mem_we_a) mem_a[mem_addr_a] <= mem_wd_a;
    if (mem_we_b) mem_b[mem_addr_b] <= mem_wd_b;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every ext_ack from dut_a must match the oldest expected ext_rd.
  always @(negedge clk) begin
    if (rst && ext_ack_a) begin
      if (exp_q.size() == 0) begin
        check_eq("ext_ack_spurious", 32'd1, 32'd0);
      end else begin
        sb_exp = exp_q.pop_front();
        check_eq("ext_rd", 32'(ext_rd_a), 32'(sb_exp));
      end
    end
  end

  task automatic cyc_set(input logic creq, input logic cwe, input logic [7:0] caddr,
                         input logic [15:0] cwd, input logic ereq, input logic ewe,
                         input logic [7:0] eaddr, input logic [15:0] ewd);
    @(posedge clk);
    #1;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wd = cwd;
    ext_req = ereq; ext_we = ewe; ext_addr = eaddr; ext_wd = ewd;
    @(negedge clk);
  endtask

  // cpu load on caddr and ext op held together for n cycles from an idle arbiter.
  task automatic run_both(input int n, input logic [7:0] caddr, input logic ewe,
                          input logic [7:0] eaddr, input logic [15:0] ewd,
                          input logic [15:0] rd_before, input logic [15:0] rd_after,
                          input bit chk_b);
    for (int i = 0; i < n; i++) begin
      cyc_set(1'b1, 1'b0, caddr, 16'h0000, 1'b1, ewe, eaddr, ewd);
      check_eq("gnt_a", 32'(ext_gnt_a), 32'((i % 6) == 4));
      check_eq("stall_a", 32'(cpu_stall_a), 32'((i % 6) == 4));
      if ((i % 6) != 4) begin
        check_eq("cpu_rd_a", 32'(cpu_rd_a), (i < 4) ? 32'(rd_before) : 32'(rd_after));
      end
      if (chk_b) begin
        check_eq("gnt_b", 32'(ext_gnt_b), 32'((i % 2) == 0));
        check_eq("stall_b", 32'(cpu_stall_b), 32'((i % 2) == 0));
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wd = 16'h1111;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'h11; ext_wd = 16'h2222;
    @(negedge clk);
    check_eq("rst_mem_we", 32'(mem_we_a), 32'd0);
    check_eq("rst_gnt", 32'(ext_gnt_a), 32'd0);
    check_eq("rst_stall", 32'(cpu_stall_a), 32'd0);
    check_eq("rst_ack", 32'(ext_ack_a), 32'd0);
    check_eq("rst_ext_rd", 32'(ext_rd_a), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cpu_req = 1'b0; ext_req = 1'b0;

    // No requester: memory follows cpu address, no write.
    cyc_set(1'b0, 1'b1, 8'h55, 16'h7777, 1'b0, 1'b0, 8'h66, 16'h0000);
    check_eq("noreq_we", 32'(mem_we_a), 32'd0);
    check_eq("noreq_addr", 32'(mem_addr_a), 32'h55);

    // cpu store then load.
    cyc_set(1'b1, 1'b1, 8'h10, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000);
    check_eq("st_we", 32'(mem_we_a), 32'd1);
    check_eq("st_stall", 32'(cpu_stall_a), 32'd0);
    check_eq("st_addr", 32'(mem_addr_a), 32'h10);
    check_eq("st_wd", 32'(mem_wd_a), 32'hBEEF);
    cyc_set(1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    check_eq("ld_rd", 32'(cpu_rd_a), 32'hBEEF);
    check_eq("ld_we", 32'(mem_we_a), 32'd0);
    cyc_set(1'b1, 1'b1, 8'h20, 16'h5555, 1'b0, 1'b0, 8'h00, 16'h0000);
    cyc_set(1'b1, 1'b1, 8'h30, 16'h1111, 1'b0, 1'b0, 8'h00, 16'h0000);

    // ext read with cpu idle; HOLD cycle must not re-grant.
    exp_q.push_back(16'hBEEF);
    cyc_set(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h10, 16'h0000);
    check_eq("ext_gnt", 32'(ext_gnt_a), 32'd1);
    check_eq("ext_stall", 32'(cpu_stall_a), 32'd0);
    check_eq("ext_addr", 32'(mem_addr_a), 32'h10);
    cyc_set(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h10, 16'h0000);
    check_eq("hold_gnt", 32'(ext_gnt_a), 32'd0);
    check_eq("hold_ack", 32'(ext_ack_a), 32'd1);
    cyc_set(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    check_eq("ack_pulse", 32'(ext_ack_a), 32'd0);

    // Contention: STARVE=4 grants every 6th cycle, STARVE=0 alternates.
    exp_q.push_back(16'hBEEF);
    exp_q.push_back(16'hBEEF);
    run_both(12, 8'h20, 1'b0, 8'h10, 16'h0000, 16'h5555, 16'h5555, 1'b1);
    cyc_set(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);

    // ext write under contention is read-old; cpu sees new data afterwards.
    exp_q.push_back(16'h5555);
    run_both(6, 8'h20, 1'b1, 8'h20, 16'h1234, 16'h5555, 16'h1234, 1'b0);
    cyc_set(1'b1, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    check_eq("ld_after_ext_wr", 32'(cpu_rd_a), 32'h1234);

    // ext_req dropped before grant clears the starvation count.
    cyc_set(1'b1, 1'b0, 8'h20, 16'h0000, 1'b1, 1'b0, 8'h10, 16'h0000);
    check_eq("drop_gnt0", 32'(ext_gnt_a), 32'd0);
    cyc_set(1'b1, 1'b0, 8'h20, 16'h0000, 1'b1, 1'b0, 8'h10, 16'h0000);
    check_eq("drop_gnt1", 32'(ext_gnt_a), 32'd0);
    cyc_set(1'b1, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b0, 8'h10, 16'h0000);
    check_eq("drop_gnt2", 32'(ext_gnt_a), 32'd0);
    exp_q.push_back(16'hBEEF);
    run_both(6, 8'h20, 1'b0, 8'h10, 16'h0000, 16'h1234, 16'h1234, 1'b0);
    cyc_set(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);

    // Async reset during an ext write grant: strobes drop, write is not committed.
    cyc_set(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h30, 16'hAAAA);
    check_eq("pre_rst_gnt", 32'(ext_gnt_a), 32'd1);
    check_eq("pre_rst_we", 32'(mem_we_a), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_gnt", 32'(ext_gnt_a), 32'd0);
    check_eq("mid_rst_we", 32'(mem_we_a), 32'd0);
    check_eq("mid_rst_ack", 32'(ext_ack_a), 32'd0);
    check_eq("mid_rst_rd", 32'(ext_rd_a), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    ext_req = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ack", 32'(ext_ack_a), 32'd0);
    cyc_set(1'b1, 1'b0, 8'h30, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    check_eq("rst_no_commit", 32'(cpu_rd_a), 32'h1111);
    exp_q.push_back(16'hBEEF);
    run_both(6, 8'h30, 1'b0, 8'h10, 16'h0000, 16'h1111, 16'h1111, 1'b0);
    cyc_set(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
